// File: rtl/lsr_shift_ctrl.sv
// Sequencer for a parallel-load, serial-out LSR driving one LED-panel data line.
// Loads a word, clocks it out MSB first, and latches with blanking after each line.
module lsr_shift_ctrl #(
  parameter int WIDTH          = 8,
  parameter int WORDS_PER_LINE = 64,
  parameter int LATCH_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_VALID,
  input  logic [WIDTH-1:0] in_DATA,
  output logic             out_READY,
  output logic [WIDTH-1:0] out_LSR_DATA,
  output logic             out_LSR_LOAD,
  output logic             out_LSR_SHIFT,
  output logic             out_SCLK,
  output logic             out_LATCH,
  output logic             out_BLANK,
  output logic             out_LINE_DONE
);

  localparam int BW = $clog2(WIDTH);
  localparam int WW = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    BIT_HI,
    BIT_LO,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WW-1:0]    word_q, word_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             load_q, shift_q, sclk_q, latch_q, blank_q;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    word_d    = word_q;
    lat_d     = lat_q;
    data_d    = data_q;
    done_d    = 1'b0;
    out_READY = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_READY = 1'b1;
        if (in_VALID) begin
          data_d  = in_DATA;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bit_d   = '0;
        state_d = BIT_HI;
      end
      BIT_HI: state_d = BIT_LO;
      BIT_LO: begin
        if (bit_q != BIT_LAST) begin
          bit_d   = bit_q + 1'b1;
          state_d = BIT_HI;
        end else if (word_q != WORD_LAST) begin
          // Accepting here lets a streaming source skip the IDLE bubble
          out_READY = 1'b1;
          word_d    = word_q + 1'b1;
          if (in_VALID) begin
            data_d  = in_DATA;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          word_d  = '0;
          lat_d   = '0;
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (lat_q == LAT_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      lat_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
      data_q  <= data_d;
      done_q  <= done_d;
      load_q  <= (state_d == LOAD);
      shift_q <= (state_d == BIT_LO);
      sclk_q  <= (state_d == BIT_HI);
      latch_q <= (state_d == LATCH);
      blank_q <= (state_d == LATCH);
    end
  end

  assign out_LSR_DATA  = data_q;
  assign out_LSR_LOAD  = load_q;
  assign out_LSR_SHIFT = shift_q;
  assign out_SCLK      = sclk_q;
  assign out_LATCH     = latch_q;
  assign out_BLANK     = blank_q;
  assign out_LINE_DONE = (state_q == IDLE) && done_q;

endmodule

// File: tb/tb_lsr_shift_ctrl.sv
// Directed bench for lsr_shift_ctrl with a behavioural LSR on each instance.
// dut2 runs WORDS_PER_LINE=2, dut4 runs WORDS_PER_LINE=4 on shared stimulus.
module tb_lsr_shift_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;

  logic       r2, ld2, sh2, sclk2, lat2, blk2, dn2;
  logic [7:0] d2;
  logic       r4, ld4, sh4, sclk4, lat4, blk4, dn4;
  logic [7:0] d4;

  lsr_shift_ctrl #(.WIDTH(8), .WORDS_PER_LINE(2), .LATCH_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .in_VALID(in_valid), .in_DATA(in_data),
    .out_READY(r2), .out_LSR_DATA(d2), .out_LSR_LOAD(ld2),
    .out_LSR_SHIFT(sh2), .out_SCLK(sclk2), .out_LATCH(lat2),
    .out_BLANK(blk2), .out_LINE_DONE(dn2)
  );

  lsr_shift_ctrl #(.WIDTH(8), .WORDS_PER_LINE(4), .LATCH_CYCLES(2)) dut4 (
    .clk(clk), .rst(rst), .in_VALID(in_valid), .in_DATA(in_data),
    .out_READY(r4), .out_LSR_DATA(d4), .out_LSR_LOAD(ld4),
    .out_LSR_SHIFT(sh4), .out_SCLK(sclk4), .out_LATCH(lat4),
    .out_BLANK(blk4), .out_LINE_DONE(dn4)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int c_ld2, c_sh2, c_lat2, c_blk2, c_dn2, c_both, c_lat4, c_dn4;
  logic [7:0] sr2, sr4;
  logic bits2[$];
  logic bits4[$];

  // LSR models: load or shift on the negedge, serial out is the MSB
  always @(negedge clk) begin
    if (ld2) sr2 <= d2;
    else if (sh2) sr2 <= {sr2[6:0], 1'b0};
    if (ld4) sr4 <= d4;
    else if (sh4) sr4 <= {sr4[6:0], 1'b0};
  end

  always @(posedge sclk2) bits2.push_back(sr2[7]);
  always @(posedge sclk4) bits4.push_back(sr4[7]);

  always @(posedge clk) begin
    if (ld2) c_ld2++;
    if (sh2) c_sh2++;
    if (lat2) c_lat2++;
    if (blk2) c_blk2++;
    if (dn2) c_dn2++;
    if ((ld2 & sh2) | (ld4 & sh4)) c_both++;
    if (lat4) c_lat4++;
    if (dn4) c_dn4++;
  end

  function automatic logic [14:0] outs2();
    return {r2, d2, ld2, sh2, sclk2, lat2, blk2, dn2};
  endfunction

  function automatic logic [7:0] byte2(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits2[8*k+i];
    return b;
  endfunction

  function automatic logic [7:0] byte4(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = bits4[8*k+i];
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    c_ld2 = 0; c_sh2 = 0; c_lat2 = 0; c_blk2 = 0; c_dn2 = 0;
    c_both = 0; c_lat4 = 0; c_dn4 = 0;
    bits2.delete();
    bits4.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w);
    in_valid = 1'b1;
    in_data = w;
    step();
    in_valid = 1'b0;
    repeat (17) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    step();
    step();
    n_cmp++;
    if (outs2() !== 15'h4000) begin
      n_fail++; $display("FAIL reset_hold: got %h want 4000", outs2());
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (outs2() !== 15'h4000) begin
        n_fail++; $display("FAIL idle_quiet[%0d]: got %h want 4000", i, outs2());
      end
    end
  endtask

  task automatic test_single_word();
    do_reset();
    clear_mon();
    n_cmp++;
    if (r2 !== 1'b1) begin
      n_fail++; $display("FAIL single_ready: got %b want 1", r2);
    end
    in_valid = 1'b1;
    in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({ld2, sh2, sclk2, d2} !== 11'b100_1010_0101) begin
      n_fail++; $display("FAIL single_load: got %b want 10010100101", {ld2, sh2, sclk2, d2});
    end
    repeat (17) step();
    n_cmp++;
    if (c_ld2 !== 1 || c_sh2 !== 8 || bits2.size() !== 8) begin
      n_fail++; $display("FAIL single_counts: got ld=%0d sh=%0d sclk=%0d want 1 8 8",
        c_ld2, c_sh2, bits2.size());
    end
    n_cmp++;
    if (bits2.size() == 8 && byte2(0) !== 8'hA5) begin
      n_fail++; $display("FAIL single_bits: got %h want a5", byte2(0));
    end
    n_cmp++;
    if ({r2, sclk2, lat2, c_lat2 == 0, c_dn2 == 0} !== 5'b10011) begin
      n_fail++; $display("FAIL single_end: got r=%b sclk=%b lat=%b nlat=%0d ndone=%0d",
        r2, sclk2, lat2, c_lat2, c_dn2);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_mon();
    in_valid = 1'b1;
    in_data = 8'hFF;
    step();
    in_data = 8'h01;
    repeat (16) step();
    n_cmp++;
    if ({r2, sh2} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_accept_window: got r=%b sh=%b want 1 1", r2, sh2);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({ld2, d2} !== 9'h101) begin
      n_fail++; $display("FAIL b2b_second_load: got ld=%b d=%h want 1 01", ld2, d2);
    end
    repeat (16) step();
    n_cmp++;
    if ({r2, sh2, lat2} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_last_bit: got r=%b sh=%b lat=%b want 0 1 0", r2, sh2, lat2);
    end
    step();
    n_cmp++;
    if ({lat2, blk2, r2, dn2} !== 4'b1100 || c_ld2 !== 2 || c_sh2 !== 16 || c_lat2 !== 0) begin
      n_fail++; $display("FAIL b2b_latch_start: got lat=%b blk=%b r=%b dn=%b ld=%0d sh=%0d",
        lat2, blk2, r2, dn2, c_ld2, c_sh2);
    end
    step();
    n_cmp++;
    if ({lat2, blk2, r2, dn2} !== 4'b1100) begin
      n_fail++; $display("FAIL b2b_latch_2nd: got %b want 1100", {lat2, blk2, r2, dn2});
    end
    step();
    n_cmp++;
    if ({lat2, blk2, r2, dn2} !== 4'b0011) begin
      n_fail++; $display("FAIL b2b_line_done: got %b want 0011", {lat2, blk2, r2, dn2});
    end
    step();
    n_cmp++;
    if (dn2 !== 1'b0 || c_lat2 !== 2 || c_blk2 !== 2 || c_dn2 !== 1) begin
      n_fail++; $display("FAIL b2b_totals: got dn=%b lat=%0d blk=%0d done=%0d want 0 2 2 1",
        dn2, c_lat2, c_blk2, c_dn2);
    end
    n_cmp++;
    if (bits2.size() !== 16 || byte2(0) !== 8'hFF || byte2(1) !== 8'h01) begin
      n_fail++; $display("FAIL b2b_bits: got n=%0d %h %h want 16 ff 01",
        bits2.size(), byte2(0), byte2(1));
    end
  endtask

  task automatic test_gap();
    do_reset();
    clear_mon();
    send_word(8'h3C);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({sclk2, r2, lat2} !== 3'b010) begin
        n_fail++; $display("FAIL gap_idle[%0d]: got %b want 010", i, {sclk2, r2, lat2});
      end
    end
    n_cmp++;
    if (bits2.size() !== 8 || c_lat2 !== 0) begin
      n_fail++; $display("FAIL gap_first: got sclk=%0d lat=%0d want 8 0", bits2.size(), c_lat2);
    end
    send_word(8'hC3);
    n_cmp++;
    if ({lat2, r2} !== 2'b10) begin
      n_fail++; $display("FAIL gap_latch: got lat=%b r=%b want 1 0", lat2, r2);
    end
    n_cmp++;
    if (bits2.size() !== 16 || byte2(0) !== 8'h3C || byte2(1) !== 8'hC3) begin
      n_fail++; $display("FAIL gap_bits: got n=%0d %h %h want 16 3c c3",
        bits2.size(), byte2(0), byte2(1));
    end
    step();
    step();
    n_cmp++;
    if (dn2 !== 1'b1) begin
      n_fail++; $display("FAIL gap_done: got %b want 1", dn2);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    clear_mon();
    send_word(8'h11);
    in_valid = 1'b1;
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    n_cmp++;
    if ({sclk2, sh2} !== 2'b10) begin
      n_fail++; $display("FAIL arst_bit4_hi: got sclk=%b sh=%b want 1 0", sclk2, sh2);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (outs2() !== 15'h4000) begin
      n_fail++; $display("FAIL arst_immediate: got %h want 4000", outs2());
    end
    step();
    rst = 1'b1;
    clear_mon();
    send_word(8'h77);
    n_cmp++;
    if ({lat2, r2} !== 2'b01 || c_lat2 !== 0) begin
      n_fail++; $display("FAIL arst_new_line: got lat=%b r=%b nlat=%0d want 0 1 0",
        lat2, r2, c_lat2);
    end
    send_word(8'h88);
    n_cmp++;
    if (lat2 !== 1'b1) begin
      n_fail++; $display("FAIL arst_latch: got %b want 1", lat2);
    end
    n_cmp++;
    if (bits2.size() !== 16 || byte2(0) !== 8'h77 || byte2(1) !== 8'h88) begin
      n_fail++; $display("FAIL arst_bits: got n=%0d %h %h want 16 77 88",
        bits2.size(), byte2(0), byte2(1));
    end
    step();
    step();
  endtask

  task automatic test_random_lines();
    logic [7:0] words[12];
    int guard;
    do_reset();
    clear_mon();
    for (int i = 0; i < 12; i++) begin
      words[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) step();
      in_valid = 1'b1;
      in_data = words[i];
      guard = 0;
      while (!r4 && guard < 200) begin
        step();
        guard++;
      end
      n_cmp++;
      if (guard >= 200) begin
        n_fail++; $display("FAIL rand_timeout[%0d]: got ready=%b want 1", i, r4);
      end
      step();
      in_valid = 1'b0;
    end
    repeat (60) step();
    n_cmp++;
    if (bits4.size() !== 96) begin
      n_fail++; $display("FAIL rand_nbits: got %0d want 96", bits4.size());
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (bits4.size() >= 8*(i+1) && byte4(i) !== words[i]) begin
        n_fail++; $display("FAIL rand_word[%0d]: got %h want %h", i, byte4(i), words[i]);
      end
    end
    n_cmp++;
    if (c_dn4 !== 3 || c_lat4 !== 6 || r4 !== 1'b1) begin
      n_fail++; $display("FAIL rand_lines: got done=%0d lat=%0d r=%b want 3 6 1",
        c_dn4, c_lat4, r4);
    end
    n_cmp++;
    if (c_both !== 0) begin
      n_fail++; $display("FAIL load_shift_overlap: got %0d want 0", c_both);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_gap();
    test_async_reset();
    test_random_lines();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
